imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate generator; sits between decode and execute.
- Decodes I/S/B/U/J/CSR/shift immediates at XLEN 32 or 64.
- Computes the PC-relative target (pc + imm) and flags illegal selector codes.
- Buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides, plus flush.

---
 rtl/imm_gen_pipe.sv | 172 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Pipelined immediate generator sitting between decode and execute.
//   Decodes the I/S/B/U/J/CSR-zimm/shift-amount immediate of a 32-bit
//   instruction at XLEN 32 or 64, forms the PC-relative target pc + imm
//   (wrapping modulo 2^XLEN) and flags the reserved selector code. Results
//   are queued in a 2-entry FIFO so the block registers every output and
//   can absorb one cycle of downstream backpressure without a bubble.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset; empties the buffer
//   flush_i        empties the buffer and drops any same-cycle request
//   valid_i        upstream request valid
//   ready_o        block can take a request this cycle (buffer not full)
//   instruction_i  raw 32-bit instruction word
//   imm_op_i       format selector: 0 I, 1 S, 2 B, 3 U, 4 J, 5 CSR, 6 SH, 7 reserved
//   pc_i           PC of the instruction
//   tag_i          opaque sideband, carried unchanged
//   valid_o        head entry valid
//   ready_i        downstream takes the head entry
//   imm_o          decoded immediate of the head entry
//   target_o       pc + imm of the head entry
//   illegal_o      head entry came from the reserved selector code
//   tag_o          tag of the head entry
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (and flush_i is low). valid does not depend on ready, an
// offered entry is held unchanged until it transfers, and ready_o depends
// only on the buffer occupancy. Output fields read 0 while valid_o is low.

module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      instruction_i,
    input  logic [2:0]       imm_op_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [XLEN-1:0]  target_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [2:0] {
        OP_I   = 3'd0,
        OP_S   = 3'd1,
        OP_B   = 3'd2,
        OP_U   = 3'd3,
        OP_J   = 3'd4,
        OP_CSR = 3'd5,
        OP_SH  = 3'd6,
        OP_RSV = 3'd7
    } imm_op_e;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] target_d;
    logic            illegal_d;

    // The opcode field does not take part in immediate extraction.
    logic unused_opcode;
    assign unused_opcode = ^instruction_i[6:0];

    // Every signed format is first assembled as a 32-bit value already
    // sign-extended from bit 31; the signed size cast then widens it to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    always_comb begin
        imm_d     = '0;
        illegal_d = 1'b0;
        unique case (imm_op_e'(imm_op_i))
            OP_I: imm_d = sext32({{20{instruction_i[31]}}, instruction_i[31:20]});
            OP_S: imm_d = sext32({{20{instruction_i[31]}}, instruction_i[31:25],
                                  instruction_i[11:7]});
            OP_B: imm_d = sext32({{19{instruction_i[31]}}, instruction_i[31],
                                  instruction_i[7], instruction_i[30:25],
                                  instruction_i[11:8], 1'b0});
            OP_U: imm_d = sext32({instruction_i[31:12], 12'b0});
            OP_J: imm_d = sext32({{11{instruction_i[31]}}, instruction_i[31],
                                  instruction_i[19:12], instruction_i[20],
                                  instruction_i[30:21], 1'b0});
            OP_CSR: imm_d = XLEN'(instruction_i[19:15]);
            OP_SH: begin
                // RV64 shift amounts take one more bit than RV32.
                if (XLEN == 64) imm_d = XLEN'(instruction_i[25:20]);
                else            imm_d = XLEN'(instruction_i[24:20]);
            end
            OP_RSV: illegal_d = 1'b1;
            default: illegal_d = 1'b1;
        endcase
    end

    // Computed for every code; only B and J consumers look at it.
    assign target_d = pc_i + imm_d;

    // ------------------------------------------------------------------
    // 2-entry FIFO
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  imm_q     [2];
    logic [XLEN-1:0]  target_q  [2];
    logic             illegal_q [2];
    logic [TAG_W-1:0] tag_q     [2];

    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign ready_o = (count != 2'd2);
    assign valid_o = (count != 2'd0);

    // Flush overrides both sides of the handshake for the cycle.
    assign push = valid_i & ready_o & ~flush_i;
    assign pop  = valid_o & ready_i & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (flush_i) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            // Push and pop together leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only visible through the head
    // pointer when count says the slot is occupied.
    always_ff @(posedge clk_i) begin
        if (push) begin
            imm_q[wr_ptr]     <= imm_d;
            target_q[wr_ptr]  <= target_d;
            illegal_q[wr_ptr] <= illegal_d;
            tag_q[wr_ptr]     <= tag_i;
        end
    end

    assign imm_o     = valid_o ? imm_q[rd_ptr]     : '0;
    assign target_o  = valid_o ? target_q[rd_ptr]  : '0;
    assign illegal_o = valid_o ? illegal_q[rd_ptr] : 1'b0;
    assign tag_o     = valid_o ? tag_q[rd_ptr]     : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
//   Bench for imm_gen_pipe. Instance 0 runs at XLEN=32, instance 1 at
//   XLEN=64. A negedge monitor keeps an expected queue of buffered entries
//   for both instances (entry carries the instance index) built from an
//   arithmetic reference decoder, and compares occupancy flags and head
//   fields every cycle.

module tb_imm_gen_pipe;

    localparam int TAG_W = 5;
    localparam int W     = 135;  // {inst, illegal, tag[4:0], imm[63:0], target[63:0]}

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // DUTs
    // ------------------------------------------------------------------
    logic [1:0]            valid_in;
    logic [1:0]            ready_in;
    logic [1:0][31:0]      instr;
    logic [1:0][2:0]       op;
    logic [1:0][63:0]      pc;
    logic [1:0][TAG_W-1:0] tag;

    wire [1:0]             valid_out;
    wire [1:0]             ready_out;
    wire [1:0]             ill_out;
    wire [1:0][63:0]       imm_out;
    wire [1:0][63:0]       tgt_out;
    wire [1:0][TAG_W-1:0]  tag_out;
    wire [31:0]            imm32;
    wire [31:0]            tgt32;

    assign imm_out[0] = {32'h0, imm32};
    assign tgt_out[0] = {32'h0, tgt32};

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .valid_i       (valid_in[0]),
        .ready_o       (ready_out[0]),
        .instruction_i (instr[0]),
        .imm_op_i      (op[0]),
        .pc_i          (pc[0][31:0]),
        .tag_i         (tag[0]),
        .valid_o       (valid_out[0]),
        .ready_i       (ready_in[0]),
        .imm_o         (imm32),
        .target_o      (tgt32),
        .illegal_o     (ill_out[0]),
        .tag_o         (tag_out[0])
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .valid_i       (valid_in[1]),
        .ready_o       (ready_out[1]),
        .instruction_i (instr[1]),
        .imm_op_i      (op[1]),
        .pc_i          (pc[1]),
        .tag_i         (tag[1]),
        .valid_o       (valid_out[1]),
        .ready_i       (ready_in[1]),
        .imm_o         (imm_out[1]),
        .target_o      (tgt_out[1]),
        .illegal_o     (ill_out[1]),
        .tag_o         (tag_out[1])
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [63:0] ref_imm(input int xlen, input logic [31:0] ins,
                                            input logic [2:0] o);
        longint s;
        longint u;
        longint r;
        s = $signed(ins);   // instruction as a signed number
        u = longint'(ins);  // instruction as an unsigned number
        case (o)
            3'd0: r = s >>> 20;
            3'd1: r = ((s >>> 25) * 32) + ((u >> 7) & 31);
            3'd2: r = ((s >>> 31) * 4096) + (((u >> 7) & 1) * 2048)
                      + (((u >> 25) & 63) * 32) + (((u >> 8) & 15) * 2);
            3'd3: r = s - (s & 4095);
            3'd4: r = ((s >>> 31) * 1048576) + (((u >> 12) & 255) * 4096)
                      + (((u >> 20) & 1) * 2048) + (((u >> 21) & 1023) * 2);
            3'd5: r = (u >> 15) & 31;
            3'd6: r = (xlen == 64) ? ((u >> 20) & 63) : ((u >> 20) & 31);
            default: r = 0;
        endcase
        if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
        return r;
    endfunction

    function automatic logic [W-1:0] make_entry(input int k, input logic [31:0] ins,
                                                input logic [2:0] o, input logic [63:0] p,
                                                input logic [TAG_W-1:0] t);
        logic [63:0] mask;
        logic [63:0] imm;
        logic [63:0] tgt;
        mask = (k == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        imm  = ref_imm((k == 1) ? 64 : 32, ins, o);
        tgt  = ((p & mask) + imm) & mask;
        return {k[0], (o == 3'd7), t, imm, tgt};
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard: expected buffer contents of both instances, oldest first
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q[$];

    function automatic int first_idx(input int k);
        for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i][134] == k[0]) return i;
        return -1;
    endfunction

    function automatic int model_count(input int k);
        int n;
        n = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i][134] == k[0]) n++;
        return n;
    endfunction

    task automatic purge(input int k);
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i][134] == k[0]) exp_q.delete(i);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int n;
            int h;
            logic [W-1:0] e;
            n = model_count(k);
            h = first_idx(k);
            if (rst) begin
                purge(k);
                check($sformatf("rst_valid%0d", k), valid_out[k], 1'b0);
                check($sformatf("rst_ready%0d", k), ready_out[k], 1'b1);
                check($sformatf("rst_imm%0d", k), imm_out[k], 64'h0);
                check($sformatf("rst_tag%0d", k), tag_out[k], 64'h0);
            end else begin
                check($sformatf("valid%0d", k), valid_out[k], n != 0);
                check($sformatf("ready%0d", k), ready_out[k], n != 2);
                if (h >= 0) begin
                    e = exp_q[h];
                    check($sformatf("imm%0d", k), imm_out[k], e[127:64]);
                    check($sformatf("target%0d", k), tgt_out[k], e[63:0]);
                    check($sformatf("illegal%0d", k), ill_out[k], e[133]);
                    check($sformatf("tag%0d", k), tag_out[k], e[132:128]);
                end else begin
                    check($sformatf("idle_imm%0d", k), imm_out[k], 64'h0);
                    check($sformatf("idle_target%0d", k), tgt_out[k], 64'h0);
                    check($sformatf("idle_illegal%0d", k), ill_out[k], 1'b0);
                    check($sformatf("idle_tag%0d", k), tag_out[k], 64'h0);
                end
                if (flush) begin
                    purge(k);
                end else begin
                    if (h >= 0 && ready_in[k]) exp_q.delete(h);
                    if (valid_in[k] && n < 2)
                        exp_q.push_back(make_entry(k, instr[k], op[k], pc[k], tag[k]));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic send(input int k, input logic [31:0] ins, input logic [2:0] o,
                        input logic [63:0] p, input logic [TAG_W-1:0] t);
        logic acc;
        int   budget;
        budget      = 0;
        acc         = 1'b0;
        valid_in[k] = 1'b1;
        instr[k]    = ins;
        op[k]       = o;
        pc[k]       = p;
        tag[k]      = t;
        while (!acc && budget < 50) begin
            @(negedge clk);
            acc = ready_out[k] && !flush;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        valid_in[k] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        valid_in = '0;
        ready_in = '1;
        instr    = '0;
        op       = '0;
        pc       = '0;
        tag      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", valid_out[0], 1'b0);
        check("reset_ready", ready_out[0], 1'b1);
        check("reset_imm", imm_out[0], 64'h0);
        check("reset_illegal", ill_out[1], 1'b0);
        rst = 1'b0;
        idle_cycles(2);

        // Directed decodes, XLEN=32
        send(0, 32'hFFF00093, 3'd0, 64'h0, 5'd1);
        check("i_valid", valid_out[0], 1'b1);
        check("i_imm", imm_out[0], 64'hFFFF_FFFF);
        check("i_illegal", ill_out[0], 1'b0);
        send(0, 32'hFE000EE3, 3'd2, 64'h100, 5'd2);
        check("b_imm", imm_out[0], 64'hFFFF_FFFC);
        check("b_target", tgt_out[0], 64'h0000_00FC);
        send(0, 32'h0080006F, 3'd4, 64'h1000, 5'd3);
        check("j_imm", imm_out[0], 64'h8);
        check("j_target", tgt_out[0], 64'h1008);
        idle_cycles(2);

        // Directed decodes, XLEN=64
        send(1, 32'h03F09093, 3'd6, 64'h0, 5'd4);
        check("sh64_imm", imm_out[1], 64'd63);
        send(1, 32'h800000B7, 3'd3, 64'h0, 5'd5);
        check("u64_imm", imm_out[1], 64'hFFFF_FFFF_8000_0000);
        send(1, 32'h800000B7, 3'd7, 64'h40, 5'd6);
        check("rsv_imm", imm_out[1], 64'h0);
        check("rsv_illegal", ill_out[1], 1'b1);
        idle_cycles(2);

        // Backpressure: tags 1,2,3 back-to-back with downstream stalled
        ready_in[0] = 1'b0;
        valid_in[0] = 1'b1;
        op[0]       = 3'd0;
        instr[0]    = $urandom;
        tag[0]      = 5'd1;
        @(posedge clk); #1;
        tag[0] = 5'd2;
        @(posedge clk); #1;
        tag[0] = 5'd3;
        check("bp_ready_low", ready_out[0], 1'b0);
        check("bp_head", tag_out[0], 64'd1);
        idle_cycles(3);
        check("bp_hold_tag", tag_out[0], 64'd1);
        check("bp_hold_ready", ready_out[0], 1'b0);
        ready_in[0] = 1'b1;
        begin
            logic acc;
            int   budget;
            acc    = 1'b0;
            budget = 0;
            while (!acc && budget < 20) begin
                @(negedge clk);
                acc = ready_out[0];
                @(posedge clk); #1;
                budget++;
            end
            if (!acc) check("bp_accept_timeout", 64'd0, 64'd1);
        end
        valid_in[0] = 1'b0;
        idle_cycles(4);

        // Flush with the buffer full and a request offered in the same cycle
        ready_in[0] = 1'b0;
        send(0, 32'h00100093, 3'd0, 64'h0, 5'd10);
        send(0, 32'h00200093, 3'd0, 64'h0, 5'd11);
        valid_in[0] = 1'b1;
        tag[0]      = 5'd9;
        flush       = 1'b1;
        @(posedge clk); #1;
        flush       = 1'b0;
        valid_in[0] = 1'b0;
        check("flush_valid", valid_out[0], 1'b0);
        check("flush_ready", ready_out[0], 1'b1);
        ready_in[0] = 1'b1;
        idle_cycles(3);
        check("flush_dropped", valid_out[0], 1'b0);

        // Asynchronous reset between edges with one entry buffered
        ready_in[0] = 1'b0;
        send(0, 32'h00500093, 3'd0, 64'h0, 5'd12);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("async_rst_valid", valid_out[0], 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", ready_out[0], 1'b1);
        ready_in[0] = 1'b1;
        send(0, 32'h7FF00093, 3'd0, 64'h0, 5'd13);
        check("post_rst_valid", valid_out[0], 1'b1);
        check("post_rst_tag", tag_out[0], 64'd13);
        idle_cycles(2);

        // Randomized traffic on both instances
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 2; k++) begin
                valid_in[k] = ($urandom_range(0, 3) != 0);
                ready_in[k] = ($urandom_range(0, 3) != 0);
                op[k]       = 3'($urandom_range(0, 7));
                instr[k]    = $urandom;
                tag[k]      = 5'($urandom_range(0, 31));
                if (k == 1) pc[k] = {$urandom, $urandom};
                else        pc[k] = {32'h0, $urandom};
            end
            flush = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        valid_in = '0;
        ready_in = '1;
        flush    = 1'b0;
        idle_cycles(4);
        check("drain_empty", exp_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
